trap_ctrl: RTL and testbench

//  Trap sequencer driving the CSR file's trap-entry/return interface: intr, intr_NO, intr_epc, mret.

---
 rtl/trap_ctrl.sv | 142 ++++++++++++++
 tb/tb_trap_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, machine-timer interrupt and mret, then redirects fetch.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when mtvec[1:0]==2'b01).
module trap_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  ecall,
    input  logic                  ebreak,
    input  logic                  illegal,
    input  logic                  mret_req,
    input  logic                  timer_irq,
    input  logic                  mstatus_mie,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    output logic                  intr,
    output logic [DATA_WIDTH-1:0] intr_NO,
    output logic [DATA_WIDTH-1:0] intr_epc,
    output logic                  mret,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [DW-1:0] IRQ_CAUSE   = (DW'(1) << (DW - 1)) | DW'(7);
    localparam logic [DW-1:0] CAUSE_ILL   = DW'(2);
    localparam logic [DW-1:0] CAUSE_BRK   = DW'(3);
    localparam logic [DW-1:0] CAUSE_ECALL = DW'(11);

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        RET,
        REDIR
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cause_q, cause_d;
    logic [DW-1:0] epc_q, epc_d;
    logic [DW-1:0] tgt_q, tgt_d;

    logic          req_exc, req_irq, req_ret;
    logic [DW-1:0] exc_cause;
    logic [DW-1:0] trap_base;
    logic [DW-1:0] trap_tgt;

    // Requests are masked during reset so every output reads 0 while rst_n is low.
    assign req_exc = rst_n & inst_valid & (illegal | ebreak | ecall);
    assign req_ret = rst_n & inst_valid & mret_req;
    assign req_irq = rst_n & inst_valid & timer_irq & mstatus_mie;

    always_comb begin
        if (illegal)     exc_cause = CAUSE_ILL;
        else if (ebreak) exc_cause = CAUSE_BRK;
        else             exc_cause = CAUSE_ECALL;
    end

    assign trap_base = {mtvec[DW-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        if (mtvec[1:0] == 2'b01 && cause_q[DW-1])
            trap_tgt = trap_base + {cause_q[DW-3:0], 2'b00};
        else
            trap_tgt = trap_base;
    end
`else
    logic unused_mode;
    assign unused_mode = ^mtvec[1:0];
    assign trap_tgt    = trap_base;
`endif

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        tgt_d          = tgt_q;
        intr           = 1'b0;
        mret           = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_exc) begin
                    stall   = 1'b1;
                    cause_d = exc_cause;
                    epc_d   = pc;
                    state_d = TRAP;
                end else if (req_ret) begin
                    stall   = 1'b1;
                    state_d = RET;
                end else if (req_irq) begin
                    stall   = 1'b1;
                    cause_d = IRQ_CAUSE;
                    epc_d   = pc;
                    state_d = TRAP;
                end
            end
            TRAP: begin
                intr    = 1'b1;
                stall   = 1'b1;
                tgt_d   = trap_tgt;
                state_d = REDIR;
            end
            RET: begin
                mret    = 1'b1;
                stall   = 1'b1;
                tgt_d   = mepc;
                state_d = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                stall          = 1'b1;
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign intr_NO     = cause_q;
    assign intr_epc    = epc_q;
    assign redirect_pc = tgt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed scoreboard bench for trap_ctrl: traps, mret, priority, handshake stall and async reset.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, ecall, ebreak, illegal, mret_req, timer_irq, mstatus_mie;
    logic [31:0] pc, mtvec, mepc;
    logic        intr, mret, stall, redirect_valid, redirect_ready;
    logic [31:0] intr_NO, intr_epc, redirect_pc;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    typedef struct {
        bit          is_mret;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];

    trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .ecall          (ecall),
        .ebreak         (ebreak),
        .illegal        (illegal),
        .mret_req       (mret_req),
        .timer_irq      (timer_irq),
        .mstatus_mie    (mstatus_mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .intr           (intr),
        .intr_NO        (intr_NO),
        .intr_epc       (intr_epc),
        .mret           (mret),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        inst_valid = 1'b0;
        ecall      = 1'b0;
        ebreak     = 1'b0;
        illegal    = 1'b0;
        mret_req   = 1'b0;
        timer_irq  = 1'b0;
    endtask

    // Caller drives the request at a negedge; this walks N, N+1, REDIR and the handshake.
    task automatic run_seq(input exp_t e, input int unsigned hold, input bit poke);
        exp_t        got;
        int unsigned n;
        sb.push_back(e);
        #1;
        check("stall_N", {31'b0, stall}, 32'd1);
        check("intr_N", {31'b0, intr}, 32'd0);
        @(negedge clk);
        clear_req();
        check("sb_nonempty", sb.size(), 32'd1);
        got = sb.pop_front();
        if (got.is_mret) begin
            check("mret_pulse", {31'b0, mret}, 32'd1);
            check("intr_on_mret", {31'b0, intr}, 32'd0);
        end else begin
            check("intr_pulse", {31'b0, intr}, 32'd1);
            check("mret_on_intr", {31'b0, mret}, 32'd0);
            check("intr_NO", intr_NO, got.cause);
            check("intr_epc", intr_epc, got.epc);
        end
        check("stall_N1", {31'b0, stall}, 32'd1);
        n = 0;
        @(negedge clk);
        while (!redirect_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("redir_valid", {31'b0, redirect_valid}, 32'd1);
        check("redir_pc", redirect_pc, got.target);
        check("intr_redir", {30'b0, intr, mret}, 32'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            if (poke) begin
                inst_valid = 1'b1;
                ecall      = 1'b1;
            end
            @(negedge clk);
            check("redir_hold_valid", {31'b0, redirect_valid}, 32'd1);
            check("redir_hold_pc", redirect_pc, got.target);
            check("redir_hold_intr", {31'b0, intr}, 32'd0);
            check("redir_hold_stall", {31'b0, stall}, 32'd1);
        end
        clear_req();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        check("idle_valid", {31'b0, redirect_valid}, 32'd0);
        check("idle_stall", {31'b0, stall}, 32'd0);
        check("idle_intr", {30'b0, intr, mret}, 32'd0);
    endtask

    function automatic exp_t mk(input bit m, input logic [31:0] c, input logic [31:0] p,
                                input logic [31:0] t);
        exp_t e;
        e.is_mret = m;
        e.cause   = c;
        e.epc     = p;
        e.target  = t;
        return e;
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] vec_t1, vec_t2;
`ifdef TRAP_VECTORED_EN
        vec_t1 = 32'h8000101C;
        vec_t2 = 32'h0000000C;
`else
        vec_t1 = 32'h80001000;
        vec_t2 = 32'hFFFFFFF0;
`endif
        rst_n          = 1'b0;
        clear_req();
        mstatus_mie    = 1'b0;
        redirect_ready = 1'b0;
        pc             = '0;
        mtvec          = 32'h80001000;
        mepc           = '0;

        // reset state
        @(negedge clk);
        check("rst_outs", {28'b0, intr, mret, stall, redirect_valid}, 32'd0);
        check("rst_intr_NO", intr_NO, 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ecall
        inst_valid = 1'b1; ecall = 1'b1; pc = 32'h80000010;
        e = mk(1'b0, 32'd11, 32'h80000010, 32'h80001000);
        run_seq(e, 0, 1'b0);

        // 2: illegal beats ecall and timer
        @(negedge clk);
        mstatus_mie = 1'b1;
        inst_valid = 1'b1; illegal = 1'b1; ecall = 1'b1; timer_irq = 1'b1; pc = 32'h80000020;
        e = mk(1'b0, 32'd2, 32'h80000020, 32'h80001000);
        run_seq(e, 0, 1'b0);
        @(negedge clk);
        check("single_trap", {31'b0, intr}, 32'd0);

        // ebreak beats ecall
        @(negedge clk);
        inst_valid = 1'b1; ebreak = 1'b1; ecall = 1'b1; pc = 32'h80000024;
        e = mk(1'b0, 32'd3, 32'h80000024, 32'h80001000);
        run_seq(e, 0, 1'b0);

        // no request without inst_valid
        @(negedge clk);
        ecall = 1'b1; pc = 32'h80000028;
        #1;
        check("no_valid_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        check("no_valid_intr", {31'b0, intr}, 32'd0);
        clear_req();

        // 3: timer masked, then enabled
        mstatus_mie = 1'b0;
        inst_valid = 1'b1; timer_irq = 1'b1; pc = 32'h80000030;
        #1;
        check("irq_masked_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        check("irq_masked_intr", {31'b0, intr}, 32'd0);
        check("irq_masked_stall2", {31'b0, stall}, 32'd0);
        mstatus_mie = 1'b1;
        e = mk(1'b0, 32'h80000007, 32'h80000030, 32'h80001000);
        run_seq(e, 0, 1'b0);

        // 4: mret
        @(negedge clk);
        mepc = 32'h80000014;
        inst_valid = 1'b1; mret_req = 1'b1; pc = 32'h80000040;
        e = mk(1'b1, 32'd0, 32'd0, 32'h80000014);
        run_seq(e, 0, 1'b0);

        // mret beats timer
        @(negedge clk);
        inst_valid = 1'b1; mret_req = 1'b1; timer_irq = 1'b1;
        e = mk(1'b1, 32'd0, 32'd0, 32'h80000014);
        run_seq(e, 0, 1'b0);

        // 5: ready held low with ecall poked during REDIR
        @(negedge clk);
        inst_valid = 1'b1; ecall = 1'b1; pc = 32'h80000050;
        e = mk(1'b0, 32'd11, 32'h80000050, 32'h80001000);
        run_seq(e, 3, 1'b1);
        @(negedge clk);
        check("no_second_intr", {31'b0, intr}, 32'd0);

        // async reset in REDIR
        inst_valid = 1'b1; ecall = 1'b1; pc = 32'h80000060;
        @(negedge clk);
        clear_req();
        @(negedge clk);
        check("pre_rst_valid", {31'b0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {28'b0, intr, mret, stall, redirect_valid}, 32'd0);
        check("rst_mid_cause", intr_NO, 32'd0);
        check("rst_mid_epc", intr_epc, 32'd0);
        check("rst_mid_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: vectored mode
        mtvec = 32'h80001001;
        inst_valid = 1'b1; timer_irq = 1'b1; pc = 32'h80000070;
        e = mk(1'b0, 32'h80000007, 32'h80000070, vec_t1);
        run_seq(e, 0, 1'b0);
        @(negedge clk);
        inst_valid = 1'b1; ecall = 1'b1; pc = 32'h80000074;
        e = mk(1'b0, 32'd11, 32'h80000074, 32'h80001000);
        run_seq(e, 0, 1'b0);

        // vector target wraps modulo 2^32
        @(negedge clk);
        mtvec = 32'hFFFFFFF1;
        inst_valid = 1'b1; timer_irq = 1'b1; pc = 32'h80000078;
        e = mk(1'b0, 32'h80000007, 32'h80000078, vec_t2);
        run_seq(e, 0, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
